// File: rtl/debug_slave_cmd_queue_if.sv
// Command handshake between the debug slave queue (producer) and its consumer.
// Carries the head entry's IR and data along with valid/ready.
interface debug_slave_cmd_queue_if #(
   parameter int DR_WIDTH = 38,
   parameter int IR_WIDTH = 2
);
   logic                cmd_valid;
   logic                cmd_ready;
   logic [IR_WIDTH-1:0] cmd_ir;
   logic [DR_WIDTH-1:0] cmd_jdo;

   modport master (
      output cmd_valid,
      output cmd_ir,
      output cmd_jdo,
      input  cmd_ready
   );

   modport slave (
      input  cmd_valid,
      input  cmd_ir,
      input  cmd_jdo,
      output cmd_ready
   );
endinterface

// File: rtl/debug_slave_cmd_queue.sv
// System-clock side of the CPU debug slave: synchronises JTAG update strobes,
// queues update-DR commands in a FWFT FIFO and decodes per-IR action pulses.
module debug_slave_cmd_queue #(
   parameter int DR_WIDTH     = 38,
   parameter int IR_WIDTH     = 2,
   parameter int SYNC_STAGES  = 2,
   parameter int FIFO_DEPTH   = 4,
   parameter int FLUSH_ON_UIR = 1,
   localparam int NCH         = 2**IR_WIDTH,
   localparam int CW          = $clog2(FIFO_DEPTH+1)
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic [DR_WIDTH-1:0] sr,
   input  logic [IR_WIDTH-1:0] ir_in,
   input  logic                vs_udr,
   input  logic                vs_uir,
   debug_slave_cmd_queue_if.master cmd,
   output logic [NCH-1:0]      take_action,
   output logic [NCH-1:0]      take_no_action,
   output logic                ir_update,
   output logic [CW-1:0]       fill_level,
   output logic                overflow,
   input  logic                overflow_clr
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [2:0] ARM_DONE = 3'(SYNC_STAGES + 1);

   logic [SYNC_STAGES-1:0] udr_sync, uir_sync;
   logic                   udr_prev, uir_prev;
   logic                   udr_evt, uir_evt;
   logic [2:0]             arm_cnt;
   logic                   armed;

   logic [IR_WIDTH-1:0] ir_mem  [FIFO_DEPTH];
   logic [DR_WIDTH-1:0] jdo_mem [FIFO_DEPTH];
   logic [AW-1:0]       wr_ptr, rd_ptr, wr_addr;
   logic                valid, push, pop, flush, full, drop, do_write;
   logic [IR_WIDTH-1:0] head_ir;
   logic [DR_WIDTH-1:0] head_jdo;

   assign armed = (arm_cnt == ARM_DONE);

   // Events are registered so the sampled sr/ir_in belong to a settled strobe;
   // during arming the edge flops follow the strobes but stay silent.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         udr_sync <= '0;
         uir_sync <= '0;
         udr_prev <= 1'b0;
         uir_prev <= 1'b0;
         udr_evt  <= 1'b0;
         uir_evt  <= 1'b0;
         arm_cnt  <= '0;
      end else begin
         udr_sync <= {udr_sync[SYNC_STAGES-2:0], vs_udr};
         uir_sync <= {uir_sync[SYNC_STAGES-2:0], vs_uir};
         udr_prev <= udr_sync[SYNC_STAGES-1];
         uir_prev <= uir_sync[SYNC_STAGES-1];
         udr_evt  <= udr_sync[SYNC_STAGES-1] & ~udr_prev & armed;
         uir_evt  <= uir_sync[SYNC_STAGES-1] & ~uir_prev & armed;
         if (!armed) arm_cnt <= arm_cnt + 3'd1;
      end
   end

   always_comb begin
      valid    = (fill_level != '0);
      head_ir  = ir_mem[rd_ptr];
      head_jdo = jdo_mem[rd_ptr];
      push     = udr_evt;
      pop      = valid & cmd.cmd_ready;
      flush    = uir_evt && (FLUSH_ON_UIR != 0);
      full     = (fill_level == CW'(FIFO_DEPTH));
      drop     = push & ~flush & full & ~pop;
      do_write = push & ~drop;
      wr_addr  = flush ? '0 : wr_ptr;
   end

   assign cmd.cmd_valid = valid;
   assign cmd.cmd_ir    = valid ? head_ir  : '0;
   assign cmd.cmd_jdo   = valid ? head_jdo : '0;

   always_ff @(posedge clk) begin
      if (do_write) begin
         ir_mem[wr_addr]  <= ir_in;
         jdo_mem[wr_addr] <= sr;
      end
   end

   // A flush empties the queue before the same-cycle push lands at slot 0.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fill_level <= '0;
      end else if (flush) begin
         rd_ptr     <= '0;
         wr_ptr     <= push ? AW'(1) : '0;
         fill_level <= push ? CW'(1) : '0;
      end else begin
         if (do_write) wr_ptr <= wr_ptr + AW'(1);
         if (pop)      rd_ptr <= rd_ptr + AW'(1);
         if (do_write && !pop)      fill_level <= fill_level + CW'(1);
         else if (!do_write && pop) fill_level <= fill_level - CW'(1);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         overflow       <= 1'b0;
         ir_update      <= 1'b0;
         take_action    <= '0;
         take_no_action <= '0;
      end else begin
         if (drop)              overflow <= 1'b1;
         else if (overflow_clr) overflow <= 1'b0;
         ir_update      <= uir_evt;
         take_action    <= '0;
         take_no_action <= '0;
         if (pop) begin
            if (head_jdo[DR_WIDTH-1]) take_action[head_ir]    <= 1'b1;
            else                      take_no_action[head_ir] <= 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_debug_slave_cmd_queue.sv
// Directed bench: one queue with update-IR flush, one without, fed identical stimulus.
module tb_debug_slave_cmd_queue;
   logic        clk = 1'b0;
   logic        reset_n;
   logic [37:0] sr;
   logic [1:0]  ir_in;
   logic        vs_udr, vs_uir, cmd_ready, overflow_clr;

   logic [3:0] ta0, tna0, ta1, tna1;
   logic       iru0, iru1, ovf0, ovf1;
   logic [2:0] fill0, fill1;

   int testsRun  = 0;
   int failCount = 0;

   debug_slave_cmd_queue_if #(.DR_WIDTH(38), .IR_WIDTH(2)) bus0 ();
   debug_slave_cmd_queue_if #(.DR_WIDTH(38), .IR_WIDTH(2)) bus1 ();
   assign bus0.cmd_ready = cmd_ready;
   assign bus1.cmd_ready = cmd_ready;

   debug_slave_cmd_queue #(.FLUSH_ON_UIR(1)) dut0 (
      .clk(clk), .reset_n(reset_n), .sr(sr), .ir_in(ir_in),
      .vs_udr(vs_udr), .vs_uir(vs_uir), .cmd(bus0.master),
      .take_action(ta0), .take_no_action(tna0), .ir_update(iru0),
      .fill_level(fill0), .overflow(ovf0), .overflow_clr(overflow_clr));

   debug_slave_cmd_queue #(.FLUSH_ON_UIR(0)) dut1 (
      .clk(clk), .reset_n(reset_n), .sr(sr), .ir_in(ir_in),
      .vs_udr(vs_udr), .vs_uir(vs_uir), .cmd(bus1.master),
      .take_action(ta1), .take_no_action(tna1), .ir_update(iru1),
      .fill_level(fill1), .overflow(ovf1), .overflow_clr(overflow_clr));

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog");
   end

   task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
      testsRun++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic [1:0] ir, input logic [37:0] data);
      ir_in  = ir;
      sr     = data;
      vs_udr = 1'b1;
      tick(4);
      vs_udr = 1'b0;
      tick(3);
   endtask

   task automatic popExpect(input string tag, input logic [7:0] b, input logic [3:0] na);
      checkOutput({tag, "_head"}, 64'(bus0.cmd_jdo[7:0]), 64'(b));
      cmd_ready = 1'b1;
      tick(1);
      cmd_ready = 1'b0;
      checkOutput({tag, "_noact"}, 64'(tna0), 64'(na));
      checkOutput({tag, "_act"}, 64'(ta0), 64'h0);
   endtask

   initial begin
      reset_n = 1'b0; sr = '0; ir_in = '0; vs_udr = 1'b1; vs_uir = 1'b0;
      cmd_ready = 1'b0; overflow_clr = 1'b0;

      // Strobe high through reset must not create a command
      tick(2);
      checkOutput("rst_fill", 64'(fill0), 64'h0);
      checkOutput("rst_valid", 64'(bus0.cmd_valid), 64'h0);
      checkOutput("rst_ovf", 64'(ovf0), 64'h0);
      checkOutput("rst_act", 64'({ta0, tna0, iru0}), 64'h0);
      reset_n = 1'b1;
      tick(10);
      checkOutput("t1_valid", 64'(bus0.cmd_valid), 64'h0);
      checkOutput("t1_fill", 64'(fill0), 64'h0);
      vs_udr = 1'b0;
      tick(4);

      // Single command with consumer ready: latency and take_action decode
      ir_in = 2'b10; sr = 38'h20_0000_00AB; cmd_ready = 1'b1; vs_udr = 1'b1;
      tick(3);
      checkOutput("t2_valid_early", 64'(bus0.cmd_valid), 64'h0);
      tick(1);
      vs_udr = 1'b0;
      checkOutput("t2_valid", 64'(bus0.cmd_valid), 64'h1);
      checkOutput("t2_ir", 64'(bus0.cmd_ir), 64'h2);
      checkOutput("t2_jdo", 64'(bus0.cmd_jdo), 64'h20_0000_00AB);
      tick(1);
      checkOutput("t2_act", 64'(ta0), 64'h4);
      checkOutput("t2_noact", 64'(tna0), 64'h0);
      checkOutput("t2_fill", 64'(fill0), 64'h0);
      tick(1);
      checkOutput("t2_act_clear", 64'(ta0), 64'h0);
      cmd_ready = 1'b0;
      tick(2);

      // Five commands into a four-entry queue
      for (int i = 1; i <= 5; i++) applyStimulus(2'b01, 38'(i));
      checkOutput("t3_fill", 64'(fill0), 64'h4);
      checkOutput("t3_ovf", 64'(ovf0), 64'h1);
      for (int i = 1; i <= 4; i++) popExpect("t3_pop", 8'(i), 4'b0010);
      checkOutput("t3_empty", 64'(fill0), 64'h0);
      overflow_clr = 1'b1; tick(1); overflow_clr = 1'b0;
      checkOutput("t3_ovf_clr", 64'(ovf0), 64'h0);

      for (int i = 0; i < 4; i++) applyStimulus(2'b01, 38'(8'h11 + i));
      checkOutput("t4_fill", 64'(fill0), 64'h4);

      // Dropped push while clear is requested: set wins
      ir_in = 2'b01; sr = 38'h99; vs_udr = 1'b1;
      tick(3);
      overflow_clr = 1'b1;
      tick(1);
      overflow_clr = 1'b0; vs_udr = 1'b0;
      checkOutput("t6_ovf_set", 64'(ovf0), 64'h1);
      checkOutput("t6_fill", 64'(fill0), 64'h4);
      tick(3);
      overflow_clr = 1'b1; tick(1); overflow_clr = 1'b0;
      checkOutput("t6_ovf_clr", 64'(ovf0), 64'h0);

      // Push and pop together on a full queue
      sr = 38'h15; vs_udr = 1'b1;
      tick(3);
      cmd_ready = 1'b1;
      tick(1);
      cmd_ready = 1'b0; vs_udr = 1'b0;
      checkOutput("t4_fill_full", 64'(fill0), 64'h4);
      checkOutput("t4_ovf", 64'(ovf0), 64'h0);
      tick(3);
      for (int i = 0; i < 4; i++) popExpect("t4_pop", 8'(8'h12 + i), 4'b0010);
      checkOutput("t4_empty", 64'(fill0), 64'h0);

      // Reset mid-operation loses queued commands
      applyStimulus(2'b11, 38'h20_0000_0041);
      checkOutput("rst2_pre", 64'(fill0), 64'h1);
      reset_n = 1'b0;
      #2;
      checkOutput("rst2_fill", 64'(fill0), 64'h0);
      checkOutput("rst2_valid", 64'(bus0.cmd_valid), 64'h0);
      tick(1);
      reset_n = 1'b1;
      tick(6);
      checkOutput("rst2_noact", 64'({ta0, tna0}), 64'h0);

      // Simultaneous update-IR and update-DR
      applyStimulus(2'b11, 38'h20_0000_0021);
      applyStimulus(2'b11, 38'h20_0000_0022);
      ir_in = 2'b00; sr = 38'h77; vs_udr = 1'b1; vs_uir = 1'b1;
      tick(4);
      vs_udr = 1'b0; vs_uir = 1'b0;
      checkOutput("t5_iru", 64'(iru0), 64'h1);
      checkOutput("t5_fill", 64'(fill0), 64'h1);
      checkOutput("t5_head", 64'(bus0.cmd_jdo[7:0]), 64'h77);
      checkOutput("t5_head_ir", 64'(bus0.cmd_ir), 64'h0);
      checkOutput("t5_noflush_iru", 64'(iru1), 64'h1);
      checkOutput("t5_noflush_fill", 64'(fill1), 64'h3);
      checkOutput("t5_noflush_head", 64'(bus1.cmd_jdo[7:0]), 64'h21);
      tick(1);
      checkOutput("t5_iru_once", 64'(iru0), 64'h0);

      $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
      $finish;
   end
endmodule
